// File: rtl/period_meter_pkg.sv
// period_meter shared definitions.
// FSM encoding and default sizing used by the meter and its sub-blocks.
package period_meter_pkg;

  localparam int CNT_W_DEF   = 27;
  localparam int TIMEOUT_DEF = 100_000_000;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus history flop for a slow async input.
// rise/fall are single-cycle strobes derived from the synchronized level.
module sync_edge (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      hist <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~hist;
  assign fall  = ~sync & hist;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow square wave in clk cycles.
// Edges are timed after the synchronizer, so its latency cancels out.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hi_cap;
  logic             hi_seen;
  logic             level;
  logic             rise;
  logic             fall;
  logic             at_limit;
  logic             take_rise;
  logic             take_to;
  logic             take_hi;

  sync_edge u_sync (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .async_in   (sig_in),
    .level      (level),
    .rise       (rise),
    .fall       (fall)
  );

  assign cnt_inc  = cnt + 1'b1;
  assign at_limit = (cnt == LIMIT);

  // a rise on the limit cycle still counts as a measurement
  assign take_rise = rise;
  assign take_to   = at_limit & ~rise;
  assign take_hi   = fall & ~hi_seen & ~at_limit;

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_cap     <= '0;
      hi_seen    <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state   <= MEASURE;
            cnt     <= '0;
            hi_seen <= 1'b0;
          end
        end
        MEASURE: begin
          unique case (1'b1)
            take_rise: begin
              period     <= cnt_inc;
              high_time  <= hi_seen ? hi_cap : '0;
              meas_valid <= 1'b1;
              timeout    <= 1'b0;
              cnt        <= '0;
              hi_seen    <= 1'b0;
            end
            take_to: begin
              state   <= IDLE;
              timeout <= 1'b1;
              cnt     <= '0;
              hi_seen <= 1'b0;
            end
            take_hi: begin
              hi_cap  <= cnt_inc;
              hi_seen <= 1'b1;
              cnt     <= cnt_inc;
            end
            default: cnt <= cnt_inc;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_edge_level: assert property (
    @(posedge clk_100MHz) disable iff (!reset)
      !(rise && !level) && !(fall && level)
  );

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL take parameter CNT_W, default 27, as the counter and result width in bits.
REQ-002 SHALL take parameter TIMEOUT, default 100_000_000, as the maximum cycles between rising edges before timeout; legal range 2..2^CNT_W-2.
REQ-003 SHALL have port clk_100MHz, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset sampled on the rising edge of clk_100MHz.
REQ-005 SHALL have port sig_in, input, 1 bit: asynchronous slow square wave to measure, e.g. the 10 Hz divider output.
REQ-006 SHALL have port period, output, CNT_W bits: cycles from one synchronized rising edge to the next.
REQ-007 SHALL have port high_time, output, CNT_W bits: cycles from a synchronized rising edge to the following falling edge.
REQ-008 SHALL have port meas_valid, output, 1 bit: one-cycle pulse when period and high_time update together.
REQ-009 SHALL have port timeout, output, 1 bit: level flag meaning no rising edge seen within TIMEOUT cycles.

Function
REQ-010 SHALL pass sig_in through a 2-flop synchronizer, then a history flop; rise = sync & ~hist, fall = ~sync & hist.
REQ-011 SHALL implement states IDLE, MEASURE; IDLE -> MEASURE on rise; MEASURE -> MEASURE on rise; MEASURE -> IDLE on timeout.
REQ-012 SHALL, on entering MEASURE from IDLE, load cnt = 0 and set the hi_seen flag to 0; no outputs update.
REQ-013 SHALL, in MEASURE with no rise or fall, increment cnt by 1 each cycle.
REQ-014 SHALL, in MEASURE on fall with hi_seen = 0, latch hi_cap = cnt + 1, set hi_seen = 1, and increment cnt.
REQ-015 SHALL, in MEASURE on rise, update outputs the following cycle: period = cnt + 1, high_time = hi_cap (0 if hi_seen = 0), and meas_valid = 1 for exactly one cycle.
REQ-016 SHALL, on the same rise as REQ-015, load cnt = 0, clear hi_seen, and deassert timeout.
REQ-017 SHALL make the synchronizer latency cancel, so an ideal 10 Hz / 50% input measures period = 10_000_000 and high_time = 5_000_000.
REQ-018 SHALL, in MEASURE when cnt + 1 == TIMEOUT without a rise, go to IDLE next cycle, set timeout = 1, and hold period and high_time.
REQ-019 SHALL ignore fall in IDLE; meas_valid SHALL never pulse on the first rise after reset or after a timeout.
REQ-020 SHALL keep cnt strictly below 2^CNT_W; no wrap-around is reachable given the REQ-002 range.
REQ-021 SHALL treat a rise coincident with cnt + 1 == TIMEOUT as a rise, not a timeout.

Reset
REQ-022 SHALL, with reset low at a clock edge, set state = IDLE, cnt = 0, hi_cap = 0, hi_seen = 0, period = 0, high_time = 0, meas_valid = 0, timeout = 0, and all synchronizer and history flops = 0.
REQ-023 SHALL, if reset is asserted mid-measurement, discard the partial count; the first rise after reset only arms MEASURE.

Structure
REQ-024 SHALL place the state encoding (IDLE = 0, MEASURE = 1) and the default CNT_W and TIMEOUT constants in the shared package.
REQ-025 SHALL place the synchronizer and edge detector in sub-module sync_edge, with ports clk_100MHz, reset, async_in, level, rise and fall.

Verification (benches use TIMEOUT = 1000, CNT_W = 12)
REQ-026 SHALL cover: reset, then square wave with 200 cycles high / 300 low -> first meas_valid after 2nd rise, period = 500, high_time = 200, then one pulse every 500 cycles.
REQ-027 SHALL cover: 10 rises 400 cycles apart, fed with random 0-99 cycle phase to the clock -> every period = 400 exactly.
REQ-028 SHALL cover: input held high 1500 cycles after one measured period -> timeout = 1 at 1000 cycles after last rise; period held; next rise gives no meas_valid; following rise clears timeout with correct period.
REQ-029 SHALL cover: reset low for 1 cycle midway through a period -> all outputs 0; next rise gives no meas_valid; the one after reports the correct period.
REQ-030 SHALL cover: rise exactly 1000 cycles after previous rise -> period = 1000, meas_valid = 1, timeout stays 0.
REQ-031 SHALL cover: 1-cycle glitch pulses (high 1, low 499) -> period = 500, high_time = 1.
